// File: rtl/mem_access_pkg.sv
// Shared codes for the memory-access stage: funct3 width codes, FSM states, byte counts.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] BYTES_B = 3'd1;
  localparam logic [2:0] BYTES_H = 3'd2;
  localparam logic [2:0] BYTES_W = 3'd4;

  typedef enum logic [1:0] {
    MemIdle   = 2'd0,
    MemAccess = 2'd1,
    MemDrain  = 2'd2
  } mem_state_e;

  // Zero marks an illegal width code: the op is consumed without touching memory.
  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return BYTES_B;
      F3_H, F3_HU: return BYTES_H;
      F3_W:        return BYTES_W;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load word according to funct3.
module load_extend
  import mem_access_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] word,
  input  logic [2:0]   funct3,
  output logic [W-1:0] result
);

  always_comb begin
    case (funct3)
      F3_B:    result = {{(W-8){word[7]}}, word[7:0]};
      F3_H:    result = {{(W-16){word[15]}}, word[15:0]};
      F3_BU:   result = {{(W-8){1'b0}}, word[7:0]};
      F3_HU:   result = {{(W-16){1'b0}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: byte-serial little-endian loads/stores, ALU pass-through,
// registered register-file write port and pipeline stall request.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [REG_W-1:0]  in_sdata,
  input  logic [REG_W-1:0]  in_alu,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_rd_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic              stall_req,
  output logic              write_enable,
  output logic [RA_W-1:0]   write_addr,
  output logic [REG_W-1:0]  write_data
);

  mem_state_e        state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [REG_W-1:0]  sdata_q, rbuf_q, word_nxt, ext_word, sdata_sh;
  logic [RA_W-1:0]   rd_q;
  logic              wen_q, ld_q;
  logic [2:0]        f3_q, n_q, iss_q, rcv_q, rcv_nxt, n_in;
  logic              fire, is_mem, rv_take, last_gnt, load_done;

  assign in_ready  = (state == MemIdle);
  assign fire      = in_valid & in_ready;
  assign is_mem    = in_load | in_store;
  assign n_in      = byte_count(in_funct3);
  assign stall_req = (state != MemIdle) | (in_valid & is_mem);

  // Responses beyond the n-th byte, or outside a load, are dropped here.
  assign rv_take   = (state != MemIdle) & ld_q & mem_rvalid & (rcv_q < n_q);
  assign rcv_nxt   = rcv_q + {2'b00, rv_take};
  assign last_gnt  = (state == MemAccess) & mem_gnt & (iss_q == n_q - 3'd1);
  // Writeback fires on the edge that captures the final byte, so the word
  // fed to the extender already includes the incoming lane.
  assign load_done = ld_q & (rcv_nxt == n_q) & ((state == MemDrain) | last_gnt);

  assign word_nxt = rv_take
    ? ((rbuf_q & ~(REG_W'(8'hFF) << {rcv_q, 3'b000})) | (REG_W'(mem_rdata) << {rcv_q, 3'b000}))
    : rbuf_q;
  assign sdata_sh = sdata_q >> {iss_q, 3'b000};

  assign mem_req   = (state == MemAccess);
  assign mem_we    = mem_req & ~ld_q;
  assign mem_addr  = mem_req ? addr_q + ADDR_W'(iss_q) : '0;
  assign mem_wdata = mem_we ? sdata_sh[7:0] : '0;

  load_extend #(.W(REG_W)) u_ext (
    .word   (word_nxt),
    .funct3 (f3_q),
    .result (ext_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MemIdle;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      MemIdle:   if (fire && is_mem && n_in != 3'd0) nxt = MemAccess;
      MemAccess: if (last_gnt) nxt = (!ld_q || load_done) ? MemIdle : MemDrain;
      MemDrain:  if (load_done) nxt = MemIdle;
      default:   nxt = MemIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= '0;
      sdata_q      <= '0;
      rbuf_q       <= '0;
      rd_q         <= '0;
      wen_q        <= 1'b0;
      ld_q         <= 1'b0;
      f3_q         <= '0;
      n_q          <= '0;
      iss_q        <= '0;
      rcv_q        <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= 1'b0;
      if (fire) begin
        if (!is_mem) begin
          if (in_rd_we && in_rd != '0) begin
            write_enable <= 1'b1;
            write_addr   <= in_rd;
            write_data   <= in_alu;
          end
        end else if (n_in != 3'd0) begin
          addr_q  <= in_addr;
          sdata_q <= in_sdata;
          rd_q    <= in_rd;
          wen_q   <= in_load & in_rd_we & (in_rd != '0);
          ld_q    <= in_load;
          f3_q    <= in_funct3;
          n_q     <= n_in;
          iss_q   <= '0;
          rcv_q   <= '0;
          rbuf_q  <= '0;
        end
      end
      if (state == MemAccess && mem_gnt) iss_q <= iss_q + 3'd1;
      if (rv_take) begin
        rcv_q  <= rcv_nxt;
        rbuf_q <= word_nxt;
      end
      if (load_done && wen_q) begin
        write_enable <= 1'b1;
        write_addr   <= rd_q;
        write_data   <= ext_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: byte-memory responder, expectation queues, literal pins.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 0, in_ready, in_load = 0, in_store = 0;
  logic [2:0]  in_funct3 = 0;
  logic [31:0] in_addr = 0, in_sdata = 0, in_alu = 0;
  logic [4:0]  in_rd = 0;
  logic        in_rd_we = 0;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        stall_req, write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  mem_access dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_sdata(in_sdata), .in_alu(in_alu),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_req(stall_req), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Byte memory; untouched locations read back a fixed address-derived pattern.
  logic [7:0] mem [logic [31:0]];
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  return ((v & 32'hFF) ^ 32'h80) - 32'h80;
      3'b001:  return ((v & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      3'b100:  return v & 32'hFF;
      3'b101:  return v & 32'hFFFF;
      default: return v;
    endcase
  endfunction

  typedef struct { logic [4:0] rd; logic [31:0] data; int due; } wb_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct { int due; logic [7:0] d; } rsp_t;
  wb_t         wbq[$];
  wr_t         stq[$];
  logic [31:0] raq[$];
  rsp_t        rspq[$];
  int          rlat = 1;
  bit          gnt_toggle = 0;
  int          rv_cnt = 0;
  int          wb_seen = 0, last_wb_cyc = 0;
  logic [31:0] last_wb_data = 0;
  rsp_t        env_r;
  wr_t         env_w;
  wb_t         cmp_e;

  // Memory controller: grants, in-order read responses rlat cycles after grant.
  initial begin
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_gnt = 0; mem_rvalid = 0; rspq.delete();
      end else begin
        mem_rvalid = 0; mem_rdata = 0;
        if (rspq.size() > 0 && rspq[0].due <= cyc) begin
          env_r = rspq.pop_front();
          mem_rvalid = 1; mem_rdata = env_r.d; rv_cnt++;
        end
        mem_gnt = gnt_toggle ? (cyc % 2 == 0) : 1'b1;
        if (mem_req && mem_gnt) begin
          if (mem_we) begin
            if (stq.size() == 0) flag("unexpected_store");
            else begin
              env_w = stq.pop_front();
              chk("st_addr", mem_addr, env_w.a);
              chk("st_data", {24'h0, mem_wdata}, {24'h0, env_w.d});
            end
            mem[mem_addr] = mem_wdata;
          end else begin
            if (raq.size() == 0) flag("unexpected_read");
            else chk("ld_addr", mem_addr, raq.pop_front());
            rspq.push_back('{cyc + rlat, mem_rd(mem_addr)});
          end
        end
      end
    end
  end

  // Register-file write port against the expectation queue.
  initial forever begin
    @(negedge clk); #1;
    if (rst && write_enable === 1'b1) begin
      wb_seen++; last_wb_data = write_data; last_wb_cyc = cyc;
      if (wbq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, none expected (cycle %0d)", write_addr, write_data, cyc);
      end else begin
        cmp_e = wbq.pop_front();
        chk("wb_addr", {27'h0, write_addr}, {27'h0, cmp_e.rd});
        chk("wb_data", write_data, cmp_e.data);
        if (cmp_e.due >= 0) chk("wb_cycle", cyc, cmp_e.due);
      end
    end
  end

  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] alu, input logic [4:0] rd,
                       input bit rwe, input bit timed, output int acc);
    int n, k;
    logic [31:0] v;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    if (!in_ready) flag("ready_timeout");
    in_valid = 1; in_load = ld; in_store = st; in_funct3 = f3; in_addr = a;
    in_sdata = sd; in_alu = alu; in_rd = rd; in_rd_we = rwe;
    acc = cyc;
    n = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : (f3 == 3'b010) ? 4 : 0;
    if (!ld && !st) begin
      if (rwe && rd != 0) wbq.push_back('{rd, alu, acc + 1});
    end else if (n != 0) begin
      if (ld) begin
        v = 0;
        for (int i = 0; i < n; i++) begin
          v |= 32'(mem_rd(a + 32'(i))) << (8 * i);
          raq.push_back(a + 32'(i));
        end
        if (rwe && rd != 0) wbq.push_back('{rd, ext(f3, v), timed ? acc + 2 + n : -1});
      end else begin
        for (int i = 0; i < n; i++) begin
          v = sd >> (8 * i);
          stq.push_back('{a + 32'(i), v[7:0]});
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0; in_load = 0; in_store = 0;
  endtask

  task automatic wait_wb(input int prev);
    int k;
    k = 0;
    while (wb_seen == prev && k < 60) begin @(negedge clk); #2; k++; end
    if (wb_seen == prev) flag("writeback_timeout");
  endtask

  int acc, prev, low, k, rvc;

  initial begin
    #1 rst = 0;
    #1;
    chk("rst_we", {31'h0, write_enable}, 0);
    chk("rst_waddr", {27'h0, write_addr}, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_req", {31'h0, mem_req}, 0);
    chk("rst_mwe", {31'h0, mem_we}, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", {24'h0, mem_wdata}, 0);
    chk("rst_stall", {31'h0, stall_req}, 0);
    chk("rst_ready", {31'h0, in_ready}, 1);
    repeat (2) @(negedge clk);
    rst = 1;

    // ALU pass-through
    prev = wb_seen;
    issue(0, 0, 3'b000, 0, 0, 32'h1234_5678, 5'd5, 1, 1, acc);
    #1 chk("alu_stall0", {31'h0, stall_req}, 0);
    idle();
    #2 chk("alu_stall1", {31'h0, stall_req}, 0);
    wait_wb(prev);
    chk("alu_data_lit", last_wb_data, 32'h1234_5678);
    chk("alu_cycle_lit", last_wb_cyc - acc, 1);

    // back-to-back ALU, plus rd=0 and rd_we=0 which must not write
    issue(0, 0, 3'b000, 0, 0, 32'h0000_0001, 5'd1, 1, 1, acc);
    issue(0, 0, 3'b000, 0, 0, 32'h0000_0002, 5'd2, 1, 1, acc);
    issue(0, 0, 3'b000, 0, 0, 32'h0000_0003, 5'd3, 1, 1, acc);
    issue(0, 0, 3'b000, 0, 0, 32'hDEAD_0000, 5'd0, 1, 1, acc);
    issue(0, 0, 3'b000, 0, 0, 32'hDEAD_0001, 5'd4, 0, 1, acc);
    idle();
    repeat (3) @(negedge clk);

    // LB / LBU
    mem[32'h100] = 8'h80;
    prev = wb_seen;
    issue(1, 0, 3'b000, 32'h100, 0, 0, 5'd6, 1, 1, acc);
    #1 chk("lb_stall_present", {31'h0, stall_req}, 1);
    idle();
    wait_wb(prev);
    chk("lb_data_lit", last_wb_data, 32'hFFFF_FF80);
    prev = wb_seen;
    issue(1, 0, 3'b100, 32'h100, 0, 0, 5'd6, 1, 1, acc);
    idle();
    wait_wb(prev);
    chk("lbu_data_lit", last_wb_data, 32'h0000_0080);

    // misaligned LW
    mem[32'h3] = 8'h11; mem[32'h4] = 8'h22; mem[32'h5] = 8'h33; mem[32'h6] = 8'h44;
    prev = wb_seen;
    issue(1, 0, 3'b010, 32'h3, 0, 0, 5'd7, 1, 1, acc);
    idle();
    wait_wb(prev);
    chk("lw_data_lit", last_wb_data, 32'h4433_2211);
    chk("lw_cycle_lit", last_wb_cyc - acc, 6);

    // SH across the address wrap
    prev = wb_seen;
    issue(0, 1, 3'b001, 32'hFFFF_FFFF, 32'hAABB_CCDD, 0, 5'd8, 1, 1, acc);
    idle();
    repeat (5) @(negedge clk);
    chk("sh_all_written", stq.size(), 0);
    chk("sh_byte0_lit", {24'h0, mem_rd(32'hFFFF_FFFF)}, 32'hDD);
    chk("sh_byte1_lit", {24'h0, mem_rd(32'h0000_0000)}, 32'hCC);
    chk("sh_no_write", wb_seen - prev, 0);

    // SW occupancy
    issue(0, 1, 3'b010, 32'h200, 32'h0102_0304, 0, 5'd8, 1, 1, acc);
    idle();
    k = 0;
    while (cyc < acc + 4 && k < 20) begin @(negedge clk); k++; end
    chk("sw_busy_c4", {31'h0, in_ready}, 0);
    @(negedge clk);
    chk("sw_ready_c5", {31'h0, in_ready}, 1);

    // halfword sign/zero extension, load through rd=0, load+store priority
    mem[32'h300] = 8'h34; mem[32'h301] = 8'hF2;
    prev = wb_seen;
    issue(1, 0, 3'b001, 32'h300, 0, 0, 5'd12, 1, 1, acc);
    idle();
    wait_wb(prev);
    chk("lh_data_lit", last_wb_data, 32'hFFFF_F234);
    issue(1, 0, 3'b101, 32'h300, 0, 0, 5'd13, 1, 1, acc);
    issue(1, 0, 3'b010, 32'h100, 0, 0, 5'd0, 1, 1, acc);
    issue(1, 1, 3'b010, 32'h200, 32'h7777_7777, 0, 5'd14, 1, 1, acc);
    idle();
    repeat (8) @(negedge clk);

    // illegal funct3 is a one-cycle no-op
    issue(1, 0, 3'b011, 32'h400, 0, 0, 5'd15, 1, 1, acc);
    idle();
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("illegal_no_req", {31'h0, mem_req}, 0);
      chk("illegal_ready", {31'h0, in_ready}, 1);
      @(negedge clk);
    end

    // LW with throttled grants and slow responses
    gnt_toggle = 1; rlat = 3;
    mem[32'h500] = 8'hDE; mem[32'h501] = 8'hAD; mem[32'h502] = 8'hBE; mem[32'h503] = 8'hEF;
    prev = wb_seen;
    issue(1, 0, 3'b010, 32'h500, 0, 0, 5'd9, 1, 0, acc);
    idle();
    low = 0; k = 0;
    #2;
    while (wb_seen == prev && k < 60) begin
      if (stall_req !== 1'b1) low++;
      @(negedge clk); #2; k++;
    end
    if (wb_seen == prev) flag("slow_lw_timeout");
    chk("slow_lw_stall_held", low, 0);
    chk("slow_lw_data_lit", last_wb_data, 32'hEFBE_ADDE);
    repeat (3) @(negedge clk);
    gnt_toggle = 0; rlat = 1;

    // reset in the middle of a LW abandons it
    mem[32'h600] = 8'h01; mem[32'h601] = 8'h02; mem[32'h602] = 8'h03; mem[32'h603] = 8'h04;
    issue(1, 0, 3'b010, 32'h600, 0, 0, 5'd10, 1, 1, acc);
    idle();
    rvc = rv_cnt; k = 0;
    while (rv_cnt < rvc + 2 && k < 20) begin @(posedge clk); k++; end
    if (rv_cnt < rvc + 2) flag("mid_lw_timeout");
    @(negedge clk); #3;
    rst = 0;
    wbq.delete(); raq.delete(); stq.delete();
    #1;
    chk("mrst_we", {31'h0, write_enable}, 0);
    chk("mrst_wdata", write_data, 0);
    chk("mrst_req", {31'h0, mem_req}, 0);
    chk("mrst_maddr", mem_addr, 0);
    chk("mrst_stall", {31'h0, stall_req}, 0);
    chk("mrst_ready", {31'h0, in_ready}, 1);
    @(negedge clk); #2;
    rst = 1;
    prev = wb_seen;
    issue(0, 0, 3'b000, 0, 0, 32'hCAFE_F00D, 5'd11, 1, 1, acc);
    idle();
    repeat (6) @(negedge clk);
    chk("post_rst_one_write", wb_seen - prev, 1);
    chk("post_rst_data_lit", last_wb_data, 32'hCAFE_F00D);

    chk("wbq_drained", wbq.size(), 0);
    chk("raq_drained", raq.size(), 0);
    chk("stq_drained", stq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1);
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage directly upstream of the register file: it accepts one executed instruction at a time, performs loads/stores over the byte-wide memory-controller port, and drives the register file's write port (`write_enable`, `write_addr`, `write_data`). Non-memory results pass through with one cycle of latency. Loads and stores are byte-serial, little-endian, and may be misaligned. While an access is in flight, the stage raises a stall request to the pipeline controller.

## Interface
- `ADDR_W`, 32, byte address width
- `REG_W`, 32, register data width (`RegLen`)
- `RA_W`, 5, register address width (`RegAddrLen`)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream holds a valid instruction
- `in_ready`  out  1  stage can accept; an instruction transfers on `in_valid & in_ready`
- `in_load`, `in_store`  in  1 each  memory-op class; both 0 means ALU result
- `in_funct3`  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- `in_addr`  in  ADDR_W  effective address
- `in_sdata`  in  REG_W  store data
- `in_alu`  in  REG_W  ALU result for non-memory ops
- `in_rd`  in  RA_W  destination register
- `in_rd_we`  in  1  instruction writes `rd`
- `mem_req`  out  1  byte request
- `mem_we`  out  1  request is a write
- `mem_addr`  out  ADDR_W  byte address
- `mem_wdata`  out  8  write byte
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  `mem_rdata` valid (one response per granted read, in order)
- `mem_rdata`  in  8  read byte
- `stall_req`  out  1  stall request to the pipeline controller
- `write_enable`  out  1  register-file write strobe
- `write_addr`  out  RA_W  register-file write address
- `write_data`  out  REG_W  register-file write data

## Operation
- States: IDLE, ACCESS, DRAIN.
- IDLE: `in_ready`=1.
  - On acceptance of a non-memory op, register the write for the next cycle; stay in IDLE.
  - On acceptance of a load or store, latch address, data, rd and funct3; set byte count n (B/BU=1, H/HU=2, W=4); clear the issue and receive counters; go to ACCESS.
- ACCESS:
  - `mem_req`=1 and `mem_addr` = latched addr + issued (mod 2^ADDR_W, wraps).
  - Store: `mem_wdata` = byte[issued] of the store data.
  - Each cycle with `mem_gnt` high increments `issued`.
  - Store: when the last byte is granted, go to IDLE.
  - Load: when the last byte is granted, go to DRAIN, or go directly to IDLE if all n bytes have already been received.
- Load receive: each `mem_rvalid` writes `mem_rdata` into byte lane `received` and increments `received`; this can happen in ACCESS or DRAIN.
- DRAIN: `mem_req`=0. When `received`==n, perform the writeback and go to IDLE.
- Load writeback value: B/H results are sign-extended, BU/HU results are zero-extended, W is passed as-is.
- Illegal funct3 (011, 110, 111) with `in_load` or `in_store`: no memory access and no write; the instruction is consumed as a 1-cycle no-op.
- `write_enable` is forced to 0 when `in_rd`==0 or `in_rd_we`==0. Stores never write.
- `in_load` and `in_store` both high is illegal; load takes priority.
- `stall_req` = (state≠IDLE) | (`in_valid` & (`in_load` | `in_store`)).
- `mem_rvalid` outside a load, or after n bytes have been received, is ignored.

## Timing
- Reset (asynchronous): state IDLE, all counters 0, and all outputs 0 (`write_enable`, `write_addr`, `write_data`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `stall_req`). `in_ready` is 1 after reset.
- Reset during an access abandons it with no writeback. The memory controller must tolerate the abandoned request.
- Outputs to the register file are registered:
  - `write_enable` is a single-cycle pulse.
  - `write_addr`/`write_data` hold their values until the next write.
- Latencies, counted from the acceptance edge at cycle 0, with `mem_gnt` held high and `mem_rvalid` one cycle after each grant:
  - ALU op: `write_enable` in cycle 1.
  - LB: request in cycle 1, rvalid in cycle 2, `write_enable` in cycle 3.
  - LW: requests in cycles 1–4, rvalid in cycles 2–5, `write_enable` in cycle 6.
  - SW: writes in cycles 1–4; `in_ready` returns in cycle 5.
- `mem_gnt` low holds `mem_addr`/`mem_wdata` stable.
- `mem_rvalid` may arrive in the same cycle as a grant for a later byte.
- Back-to-back ALU ops sustain one instruction per cycle.

## Structure
- `config.vh` additions:
  - funct3 load/store codes
  - state encodings (`MemIdle`, `MemAccess`, `MemDrain`)
  - byte-count constants
- The existing `ResetDisable`-style constants stay as they are. This block uses its own active-low check.
- Sub-module `load_extend`: combinational block that takes the assembled 32-bit word and funct3 and produces the sign/zero-extended result.

## Test plan
- ALU op with rd=5 and `in_alu`=0x1234_5678 → `write_enable`=1, addr 5, data 0x1234_5678 in cycle 1; `stall_req` stays 0.
- LB from address 0x100 returning 0x80 → write data 0xFFFF_FF80. LBU with the same stimulus → 0x0000_0080.
- LW from address 0x0003 with bytes 11, 22, 33, 44 → requests to 0x3–0x6; write 0x4433_2211 in cycle 6.
- SH with data 0xAABB_CCDD at address 0xFFFF_FFFF → byte writes DD@0xFFFF_FFFF and CC@0x0000_0000 (address wraps); no register write.
- LW with `mem_gnt` toggled low every other cycle and rvalid delayed 3 cycles → correct word; `stall_req` stays high until the write cycle.
- `rst` pulsed low mid-LW (after 2 bytes) → all outputs 0 immediately; the next ALU op writes correctly with no stale write.
